// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU control path: writeback sequencer state and DataMUX select codes.
package cpu_ctrl_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic SEL_ALU = 1'b0;
    localparam logic SEL_RAM = 1'b1;

endpackage

// File: rtl/wait_timer.sv
// Cycle counter for memory waits: cleared on entry, counts while enabled, flags the last
// permitted cycle so the sequencer can abort a hung access.
module wait_timer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Width leaves headroom for the increment in the expiring cycle, so no wrap.
    assign expire = enable && !clear && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: steers the registered DataMUX, issues register-file writes one cycle
// after capture, and runs the RAM req/ack handshake with stall and timeout abort.
module wb_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int REG_ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic                  instr_is_load,
    input  logic                  instr_is_store,
    input  logic                  instr_wr_rd,
    input  logic [REG_ADDR_W-1:0] instr_rd,
    input  logic                  ram_ack,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic                  mux_select,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic                  stall,
    output logic                  timeout_err
);

    state_e                  state_q, state_d;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic                    store_q, store_d;
    logic                    rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic                    err_q, err_d;
    logic                    mem_op;
    logic                    timer_clear;
    logic                    timer_expire;

    assign mem_op = instr_is_load || instr_is_store;

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        store_d     = store_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        err_d       = err_q;
        timer_clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (instr_valid && mem_op) begin
                    state_d     = MEM_WAIT;
                    rd_d        = instr_rd;
                    // A load+store encoding is resolved as a load.
                    store_d     = instr_is_store && !instr_is_load;
                    timer_clear = 1'b1;
                end else if (instr_valid && instr_wr_rd && (instr_rd != '0)) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = instr_rd;
                end
            end
            MEM_WAIT: begin
                // An ack in the expiring cycle still completes normally.
                if (ram_ack) begin
                    state_d = IDLE;
                    if (!store_q && (rd_q != '0)) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = rd_q;
                    end
                end else if (timer_expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            store_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            store_q    <= store_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            err_q      <= err_d;
        end
    end

    wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (state_q == MEM_WAIT),
        .expire (timer_expire)
    );

    assign ram_req     = (state_q == MEM_WAIT);
    assign ram_we      = ram_req && store_q;
    assign mux_select  = ram_req ? SEL_RAM : SEL_ALU;
    assign stall       = ram_req || (instr_valid && mem_op);
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign timeout_err = err_q;

endmodule
